// File: rtl/tcb_peri_gpio_int.sv
// Per-pin debounce and sticky, maskable interrupt status for the TCB GPIO peripheral.
// Consumes the CDC-synchronized gpio_r vector; irq is an AND-OR of flops only.
module tcb_peri_gpio_int #(
  parameter int unsigned DAT = 32,
  parameter int unsigned DBW = 8
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [DAT-1:0] gpio_r,
  input  logic [DBW-1:0] cfg_dbc,
  input  logic [DAT-1:0] cfg_rise,
  input  logic [DAT-1:0] cfg_fall,
  input  logic [DAT-1:0] cfg_lvlh,
  input  logic [DAT-1:0] cfg_lvll,
  input  logic [DAT-1:0] cfg_ien,
  input  logic [DAT-1:0] sts_clr,
  output logic [DAT-1:0] gpio_d,
  output logic [DAT-1:0] sts,
  output logic           irq
);

  logic [DBW-1:0] cnt [DAT];
  logic [DAT-1:0] dif;
  logic [DAT-1:0] upd;
  logic [DAT-1:0] evt;

  // Pending-change detection and threshold reached (>= so a lowered threshold acts at once)
  always_comb begin
    dif = gpio_r ^ gpio_d;
    upd = '0;
    for (int unsigned i = 0; i < DAT; i++) begin
      upd[i] = dif[i] && (cnt[i] >= cfg_dbc);
    end
  end

  // Edge events qualify on the update strobe; level events use the registered value
  always_comb begin
    evt = (upd &  gpio_r & cfg_rise)
        | (upd & ~gpio_r & cfg_fall)
        | ( gpio_d & cfg_lvlh)
        | (~gpio_d & cfg_lvll);
  end

  // Debounce counters, debounced value and sticky status (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_d <= '0;
      sts    <= '0;
      for (int unsigned i = 0; i < DAT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DAT; i++) begin
        if (!dif[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DBW'(1);
        end
      end
      gpio_d <= (gpio_d & ~upd) | (gpio_r & upd);
      sts    <= evt | (sts & ~sts_clr);
    end
  end

  assign irq = |(sts & cfg_ien);

endmodule

// File: tb/tb_tcb_peri_gpio_int.sv
// Scoreboard bench for tcb_peri_gpio_int: a cycle model pushes expected state,
// which is popped and compared one step after each clock edge.
module tb_tcb_peri_gpio_int;

  localparam int unsigned DAT = 32;
  localparam int unsigned DBW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [DAT-1:0] gpio_r;
  logic [DBW-1:0] cfg_dbc;
  logic [DAT-1:0] cfg_rise, cfg_fall, cfg_lvlh, cfg_lvll, cfg_ien, sts_clr;
  logic [DAT-1:0] gpio_d, sts;
  logic           irq;

  tcb_peri_gpio_int #(.DAT(DAT), .DBW(DBW)) dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_r   (gpio_r),
    .cfg_dbc  (cfg_dbc),
    .cfg_rise (cfg_rise),
    .cfg_fall (cfg_fall),
    .cfg_lvlh (cfg_lvlh),
    .cfg_lvll (cfg_lvll),
    .cfg_ien  (cfg_ien),
    .sts_clr  (sts_clr),
    .gpio_d   (gpio_d),
    .sts      (sts),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DAT-1:0] d;
    logic [DAT-1:0] s;
    logic           irq;
  } exp_t;

  exp_t           sb[$];
  logic [DAT-1:0] m_d;
  logic [DAT-1:0] m_sts;
  int             m_cnt [DAT];
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string tag, input logic [DAT-1:0] obs, input logic [DAT-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_d   = '0;
    m_sts = '0;
    for (int i = 0; i < DAT; i++) m_cnt[i] = 0;
  endfunction

  // One rising edge of the reference behaviour, using the currently driven inputs
  function automatic void model_edge();
    logic [DAT-1:0] up;
    logic [DAT-1:0] ev;
    up = '0;
    for (int i = 0; i < DAT; i++) begin
      if (gpio_r[i] == m_d[i]) m_cnt[i] = 0;
      else if (m_cnt[i] >= int'(cfg_dbc)) begin
        up[i]    = 1'b1;
        m_cnt[i] = 0;
      end else m_cnt[i] = m_cnt[i] + 1;
    end
    ev = (up & gpio_r & cfg_rise) | (up & ~gpio_r & cfg_fall)
       | (m_d & cfg_lvlh) | (~m_d & cfg_lvll);
    m_sts = ev | (m_sts & ~sts_clr);
    m_d   = (m_d & ~up) | (gpio_r & up);
  endfunction

  task automatic step(input string tag);
    exp_t e;
    model_edge();
    e.d   = m_d;
    e.s   = m_sts;
    e.irq = |(m_sts & cfg_ien);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_gpio_d"}, gpio_d, e.d);
    check({tag, "_sts"}, sts, e.s);
    check({tag, "_irq"}, DAT'(irq), DAT'(e.irq));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    gpio_r = '0; cfg_dbc = '0; cfg_rise = '0; cfg_fall = '0;
    cfg_lvlh = '0; cfg_lvll = '0; cfg_ien = '0; sts_clr = '0;
    model_reset();
    #3;
    check("rst_gpio_d", gpio_d, '0);
    check("rst_sts", sts, '0);
    check("rst_irq", DAT'(irq), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Debounce threshold and glitch rejection
    cfg_dbc = 8'd3;
    gpio_r  = 32'h1;
    repeat (3) step("dbc_wait");
    check("dbc_before_4th", gpio_d, 32'h0);
    step("dbc_4th");
    check("dbc_at_4th", gpio_d, 32'h1);
    for (int p = 0; p < 2; p++) begin
      gpio_r = 32'h0;
      repeat (3) step("glitch_low");
      gpio_r = 32'h1;
      step("glitch_back");
      check("glitch_swallowed", gpio_d, 32'h1);
    end

    // Edge events and clear
    cfg_dbc = 8'd0;
    gpio_r  = 32'h0;
    step("fall_nocfg0");
    check("dbc0_fall", gpio_d, 32'h0);
    cfg_rise = 32'h1; cfg_ien = 32'h1; gpio_r = 32'h1;
    step("rise_evt");
    check("rise_sts", sts, 32'h1);
    check("rise_irq", DAT'(irq), 32'h1);
    sts_clr = 32'h1;
    step("clr");
    sts_clr = '0;
    check("clr_sts", sts, 32'h0);
    check("clr_irq", DAT'(irq), 32'h0);
    gpio_r = 32'h0;
    step("fall_dis");
    check("fall_dis_sts", sts, 32'h0);

    // Set/clear collision and level persistence
    cfg_rise = 32'h21; gpio_r = 32'h20; sts_clr = 32'h20;
    step("collide");
    sts_clr = '0;
    check("collide_sts", sts, 32'h20);
    cfg_lvlh = 32'h20;
    for (int k = 0; k < 3; k++) begin
      sts_clr = 32'h20;
      step("lvl_clr");
      check("lvl_hold", sts & 32'h20, 32'h20);
    end
    cfg_lvlh = '0; sts_clr = '1;
    step("cleanup");
    sts_clr = '0;
    check("cleanup_sts", sts, 32'h0);

    // Masking
    cfg_ien = '0; cfg_rise = 32'h8000_0001; gpio_r = 32'h8000_0021;
    step("mask");
    check("mask_sts", sts, 32'h8000_0001);
    check("mask_irq", DAT'(irq), 32'h0);
    cfg_ien = 32'h8000_0000;
    #1;
    check("unmask_irq", DAT'(irq), 32'h1);
    @(negedge clk);

    // Reset mid-count, then pin-high-through-reset rising events
    cfg_dbc = 8'd10;
    gpio_r  = 32'h8000_0025;
    repeat (5) step("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_gpio_d", gpio_d, '0);
    check("arst_sts", sts, '0);
    check("arst_irq", DAT'(irq), '0);
    model_reset();
    gpio_r = '1; cfg_dbc = 8'd2; cfg_rise = '1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step("post_rst");
    check("post_rst_wait", gpio_d, '0);
    step("post_rst_3rd");
    check("post_rst_gpio_d", gpio_d, '1);
    check("post_rst_sts", sts, '1);

    // Lowering the threshold mid-count
    cfg_rise = '0; sts_clr = '1;
    step("pre_thr");
    sts_clr = '0;
    cfg_dbc = 8'd10; gpio_r = '0;
    repeat (6) step("thr_count");
    check("thr_pending", gpio_d, '1);
    cfg_dbc = 8'd4;
    step("thr_lower");
    check("thr_update", gpio_d, '0);

    // Randomised traffic against the model
    cfg_dbc  = DBW'($urandom_range(0, 3));
    cfg_rise = $urandom; cfg_fall = $urandom;
    cfg_lvlh = $urandom & $urandom & $urandom;
    cfg_lvll = $urandom & $urandom & $urandom;
    cfg_ien  = $urandom;
    for (int n = 0; n < 300; n++) begin
      gpio_r  = gpio_r ^ ($urandom & $urandom & $urandom);
      sts_clr = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      if (n % 50 == 49) cfg_dbc = DBW'($urandom_range(0, 4));
      step("rand");
    end

    check("sb_drain", DAT'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
